// File: rtl/mem_port_arbiter_pkg.sv
// Shared widths, bus field offsets and owner encoding for the memory-port arbiter.
package mem_port_arbiter_pkg;

  localparam int MEM_REQ_BUS_WD = 71;

  // *_req_bus = {wr, size[1:0], wstrb[3:0], addr[31:0], wdata[31:0]}
  localparam int BUS_WR_BIT    = 70;
  localparam int BUS_SIZE_LSB  = 68;
  localparam int BUS_WSTRB_LSB = 64;
  localparam int BUS_ADDR_LSB  = 32;
  localparam int BUS_WDATA_LSB = 0;

  // Owner tag stored per outstanding transaction.
  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_port_arbiter_owner_fifo.sv
// In-order 1-bit owner FIFO: records who issued each accepted request so the
// matching response can be steered back.
module owner_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0] mem;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage, pointers and occupancy; push and pop in one cycle leave count unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one req/addr_ok/data_ok memory port between fetch and load/store.
// Data wins when no grant is held; a stalled grant is held until addr_ok.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int OUTSTANDING = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      inst_req,
  input  logic [MEM_REQ_BUS_WD-1:0] inst_req_bus,
  output logic                      inst_addr_ok,
  output logic                      inst_data_ok,
  output logic [31:0]               inst_rdata,
  input  logic                      data_req,
  input  logic [MEM_REQ_BUS_WD-1:0] data_req_bus,
  output logic                      data_addr_ok,
  output logic                      data_data_ok,
  output logic [31:0]               data_rdata,
  output logic                      mem_req,
  output logic [MEM_REQ_BUS_WD-1:0] mem_req_bus,
  input  logic                      mem_addr_ok,
  input  logic                      mem_data_ok,
  input  logic [31:0]               mem_rdata
);

  logic   hold_valid;
  owner_e hold_owner;
  logic   grant_data, gnt_req;
  logic   fifo_full, fifo_empty, fifo_head;
  logic   push, pop;

  // Grant select: a held owner sticks; otherwise data first, data also the idle default.
  always_comb begin
    grant_data = data_req | ~inst_req;
    if (hold_valid && !reset) grant_data = (hold_owner == OWN_DATA);
  end

  assign gnt_req     = grant_data ? data_req : inst_req;
  assign mem_req     = gnt_req & ~fifo_full & ~reset;
  assign mem_req_bus = grant_data ? data_req_bus : inst_req_bus;

  assign push         = mem_req & mem_addr_ok;
  assign inst_addr_ok = push & ~grant_data;
  assign data_addr_ok = push & grant_data;

  // Responses with nothing outstanding (including stale pre-reset ones) are dropped.
  assign pop          = mem_data_ok & ~fifo_empty & ~reset;
  assign inst_data_ok = pop & (fifo_head == OWN_INST);
  assign data_data_ok = pop & (fifo_head == OWN_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // Grant hold: latch the owner on a stalled request, release when the port accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      hold_owner <= OWN_INST;
    end else if (mem_addr_ok) begin
      hold_valid <= 1'b0;
    end else if (mem_req) begin
      hold_valid <= 1'b1;
      hold_owner <= grant_data ? OWN_DATA : OWN_INST;
    end
  end

  owner_fifo #(.DEPTH(OUTSTANDING)) u_owner_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (grant_data),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed cycle table plus a randomized stall run with an owner scoreboard.
module tb_mem_port_arbiter;

  localparam int OUTSTANDING = 2;
  localparam logic [70:0] INST_BUS = {1'b0, 2'b10, 4'h0, 32'h1c000000, 32'h00000000};
  localparam logic [70:0] DATA_BUS = {1'b1, 2'b10, 4'hf, 32'h80001000, 32'hdeadbeef};

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req, data_req;
  logic [70:0] inst_req_bus, data_req_bus;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req;
  logic [70:0] mem_req_bus;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.OUTSTANDING(OUTSTANDING)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_req_bus (inst_req_bus),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_req_bus (data_req_bus),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_req_bus  (mem_req_bus),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  typedef struct {
    logic        rst, ir, dr, aok, dok;
    logic [31:0] rd;
    logic        mreq, dsel, iaok, daok, idok, ddok;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t V(input logic rst, ir, dr, aok, dok, input logic [31:0] rd,
                             input logic mreq, dsel, iaok, daok, idok, ddok);
    vec_t v;
    v.rst = rst; v.ir = ir; v.dr = dr; v.aok = aok; v.dok = dok; v.rd = rd;
    v.mreq = mreq; v.dsel = dsel; v.iaok = iaok; v.daok = daok; v.idok = idok; v.ddok = ddok;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    logic        ip, dp, prev_stall, o, psh;
    logic [70:0] ib, db, prev_bus;
    logic        q[$];

    reset = 1'b1; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    mem_rdata = 0; inst_req_bus = INST_BUS; data_req_bus = DATA_BUS;

    //        rst ir dr aok dok rd            mreq dsel iaok daok idok ddok
    tbl.push_back(V(1, 0, 0, 0, 0, 32'h0,        0, 1, 0, 0, 0, 0)); // reset
    tbl.push_back(V(0, 1, 0, 1, 0, 32'h0,        1, 0, 1, 0, 0, 0)); // fetch accepted
    tbl.push_back(V(0, 0, 0, 0, 0, 32'h0,        0, 1, 0, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0, 1, 32'h02800c0c, 0, 1, 0, 0, 1, 0)); // fetch response
    tbl.push_back(V(0, 0, 0, 0, 1, 32'h00001234, 0, 1, 0, 0, 0, 0)); // spurious
    tbl.push_back(V(0, 1, 1, 0, 0, 32'h0,        1, 1, 0, 0, 0, 0)); // data wins, stall
    tbl.push_back(V(0, 1, 0, 0, 0, 32'h0,        0, 1, 0, 0, 0, 0)); // data dropped, still held
    tbl.push_back(V(0, 1, 0, 1, 0, 32'h0,        0, 1, 0, 0, 0, 0)); // release on addr_ok
    tbl.push_back(V(0, 1, 0, 0, 0, 32'h0,        1, 0, 0, 0, 0, 0)); // inst stalls
    tbl.push_back(V(0, 1, 1, 0, 0, 32'h0,        1, 0, 0, 0, 0, 0)); // inst held vs data
    tbl.push_back(V(0, 1, 1, 1, 0, 32'h0,        1, 0, 1, 0, 0, 0)); // inst accepted (q: I)
    tbl.push_back(V(0, 0, 1, 1, 0, 32'h0,        1, 1, 0, 1, 0, 0)); // data accepted (q: I D)
    tbl.push_back(V(0, 0, 1, 1, 0, 32'h0,        0, 1, 0, 0, 0, 0)); // full
    tbl.push_back(V(0, 0, 1, 1, 1, 32'h0000000a, 0, 1, 0, 0, 1, 0)); // full, pop no bypass
    tbl.push_back(V(0, 0, 1, 1, 0, 32'h0,        1, 1, 0, 1, 0, 0)); // issues next cycle (q: D D)
    tbl.push_back(V(0, 0, 0, 0, 1, 32'h0000000b, 0, 1, 0, 0, 0, 1)); // data response (q: D)
    tbl.push_back(V(0, 1, 0, 1, 0, 32'h0,        1, 0, 1, 0, 0, 0)); // q: D I
    tbl.push_back(V(1, 0, 1, 1, 0, 32'h0,        0, 1, 0, 0, 0, 0)); // reset mid-flight
    tbl.push_back(V(1, 0, 0, 0, 1, 32'h0000000c, 0, 1, 0, 0, 0, 0));
    tbl.push_back(V(0, 0, 0, 0, 1, 32'h0000000d, 0, 1, 0, 0, 0, 0)); // stale response dropped
    tbl.push_back(V(0, 1, 0, 1, 0, 32'h0,        1, 0, 1, 0, 0, 0)); // q: I
    tbl.push_back(V(0, 0, 1, 1, 0, 32'h0,        1, 1, 0, 1, 0, 0)); // q: I D
    tbl.push_back(V(0, 0, 1, 1, 0, 32'h0,        0, 1, 0, 0, 0, 0)); // full: count was 0 after reset
    tbl.push_back(V(0, 0, 0, 0, 1, 32'h00000011, 0, 1, 0, 0, 1, 0));
    tbl.push_back(V(0, 0, 0, 0, 1, 32'h00000022, 0, 1, 0, 0, 0, 1));
    tbl.push_back(V(0, 0, 0, 0, 1, 32'h00000033, 0, 1, 0, 0, 0, 0)); // empty again

    foreach (tbl[i]) begin
      @(negedge clk);
      reset = tbl[i].rst; inst_req = tbl[i].ir; data_req = tbl[i].dr;
      mem_addr_ok = tbl[i].aok; mem_data_ok = tbl[i].dok; mem_rdata = tbl[i].rd;
      #1;
      chk("flags", i, {mem_req, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok},
          {tbl[i].mreq, tbl[i].iaok, tbl[i].daok, tbl[i].idok, tbl[i].ddok});
      chk("bus", i, mem_req_bus, tbl[i].dsel ? DATA_BUS : INST_BUS);
      chk("rdata", i, {inst_rdata, data_rdata}, {tbl[i].rd, tbl[i].rd});
    end

    // Randomized stalls; requesters hold req/bus stable until accepted.
    @(negedge clk);
    reset = 1'b1; inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0;
    @(negedge clk);
    reset = 1'b0;
    ip = 0; dp = 0; prev_stall = 0; prev_bus = '0; ib = INST_BUS; db = DATA_BUS;
    for (int c = 0; c < 10000; c++) begin
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1; ib = {1'b0, 6'($urandom), $urandom, $urandom};
      end
      if (!dp && $urandom_range(0, 3) == 0) begin
        dp = 1; db = {1'b1, 6'($urandom), $urandom, $urandom};
      end
      inst_req = ip; inst_req_bus = ib; data_req = dp; data_req_bus = db;
      mem_addr_ok = ($urandom_range(0, 2) != 0);
      mem_data_ok = (q.size() > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
      mem_rdata = $urandom;
      #1;
      chk("issue", c, mem_req, (ip | dp) && (q.size() < OUTSTANDING));
      if (prev_stall) chk("hold_bus", c, mem_req_bus, prev_bus);
      if (mem_data_ok) begin
        if (q.size() > 0) begin
          o = q.pop_front();
          chk("route", c, {inst_data_ok, data_data_ok}, {~o, o});
        end else begin
          chk("spurious", c, {inst_data_ok, data_data_ok}, 2'b00);
        end
      end else begin
        chk("idle_ok", c, {inst_data_ok, data_data_ok}, 2'b00);
      end
      psh = mem_req & mem_addr_ok;
      chk("addr_ok", c, {inst_addr_ok, data_addr_ok}, {psh & ~mem_req_bus[70], psh & mem_req_bus[70]});
      if (psh) q.push_back(mem_req_bus[70]);
      prev_stall = mem_req & ~mem_addr_ok;
      prev_bus   = mem_req_bus;
      if (inst_addr_ok) ip = 0;
      if (data_addr_ok) dp = 0;
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
